// File: rtl/cpu_wb_port_arbiter_if.sv
// Bus bundle between the execute/commit stages and the register-file write-port arbiter.
// The master side drives the write requests and lookups; the slave side is the arbiter.
interface cpu_wb_port_arbiter_if #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 32,
    parameter int BUF_DEPTH = 2
);
    localparam int RD_W  = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic                 mul_valid;
    logic [RD_W-1:0]      mul_rd;
    logic [REG_WIDTH-1:0] mul_data;
    logic                 pipe_valid;
    logic [RD_W-1:0]      pipe_rd;
    logic [REG_WIDTH-1:0] pipe_data;
    logic                 pipe_stall;
    logic                 rf_we;
    logic [RD_W-1:0]      rf_waddr;
    logic [REG_WIDTH-1:0] rf_wdata;
    logic [CNT_W-1:0]     buf_count;
    logic [RD_W-1:0]      query_rd;
    logic                 query_hit;
    logic [REG_WIDTH-1:0] query_data;

    modport master (
        output mul_valid, mul_rd, mul_data,
        output pipe_valid, pipe_rd, pipe_data,
        output query_rd,
        input  pipe_stall, rf_we, rf_waddr, rf_wdata, buf_count,
        input  query_hit, query_data
    );

    modport slave (
        input  mul_valid, mul_rd, mul_data,
        input  pipe_valid, pipe_rd, pipe_data,
        input  query_rd,
        output pipe_stall, rf_we, rf_waddr, rf_wdata, buf_count,
        output query_hit, query_data
    );
endinterface

// File: rtl/cpu_wb_port_arbiter.sv
// Register-file write-port arbiter: the multiplier exit always wins, colliding writeback
// writes wait in an in-order buffer that drains on multiplier-free cycles.
module cpu_wb_port_arbiter #(
    parameter int REG_WIDTH = 32,
    parameter int NUM_REGS  = 32,
    parameter int BUF_DEPTH = 2
) (
    input logic                  clock,
    input logic                  reset,
    cpu_wb_port_arbiter_if.slave bus
);
    localparam int RD_W  = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [RD_W-1:0]      buf_rd_q   [BUF_DEPTH];
    logic [RD_W-1:0]      buf_rd_d   [BUF_DEPTH];
    logic [REG_WIDTH-1:0] buf_data_q [BUF_DEPTH];
    logic [REG_WIDTH-1:0] buf_data_d [BUF_DEPTH];
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 rf_we_q, rf_we_d;
    logic [RD_W-1:0]      rf_waddr_q, rf_waddr_d;
    logic [REG_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic                 full_s, empty_s, stall_s, accept_s;
    logic                 pop_s, direct_s, push_s;
    logic                 query_hit_s;
    logic [REG_WIDTH-1:0] query_data_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    // Handshake decisions; a direct write is only legal with no mul and nothing buffered.
    always_comb begin
        full_s   = (count_q == CNT_W'(BUF_DEPTH));
        empty_s  = (count_q == {CNT_W{1'b0}});
        stall_s  = bus.mul_valid && full_s;
        accept_s = bus.pipe_valid && !stall_s;
        pop_s    = !bus.mul_valid && !empty_s;
        direct_s = !bus.mul_valid && empty_s && bus.pipe_valid;
        push_s   = accept_s && !direct_s;
    end

    // Port selection, buffer push/pop and occupancy update.
    always_comb begin
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (bus.mul_valid) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.mul_rd;
            rf_wdata_d = bus.mul_data;
        end else if (pop_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = buf_rd_q[head_q];
            rf_wdata_d = buf_data_q[head_q];
            head_d     = ptr_inc(head_q);
        end else if (direct_s) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.pipe_rd;
            rf_wdata_d = bus.pipe_data;
        end else begin
            rf_we_d    = 1'b0;
        end

        if (push_s) begin
            buf_rd_d[tail_q]   = bus.pipe_rd;
            buf_data_d[tail_q] = bus.pipe_data;
            tail_d             = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end

        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1'b1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // State registers; reset flushes the buffer and drops any pending port write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_rd_q[i]   <= {RD_W{1'b0}};
                buf_data_q[i] <= {REG_WIDTH{1'b0}};
            end
            head_q     <= {PTR_W{1'b0}};
            tail_q     <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {RD_W{1'b0}};
            rf_wdata_q <= {REG_WIDTH{1'b0}};
        end else begin
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Forwarding lookup: output register first, then head to tail so the youngest match wins.
    always_comb begin
        query_hit_s  = 1'b0;
        query_data_s = {REG_WIDTH{1'b0}};
        if (rf_we_q && (rf_waddr_q == bus.query_rd)) begin
            query_hit_s  = 1'b1;
            query_data_s = rf_wdata_q;
        end else begin
            query_hit_s  = 1'b0;
        end
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (buf_rd_q[PTR_W'((int'(head_q) + i) % BUF_DEPTH)] == bus.query_rd)) begin
                query_hit_s  = 1'b1;
                query_data_s = buf_data_q[PTR_W'((int'(head_q) + i) % BUF_DEPTH)];
            end else begin
                query_hit_s  = query_hit_s;
            end
        end
    end

    assign bus.pipe_stall = stall_s;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.buf_count  = count_q;
    assign bus.query_hit  = query_hit_s;
    assign bus.query_data = query_data_s;
endmodule

// File: doc/cpu_wb_port_arbiter.md
# cpu_wb_port_arbiter

Shares the single register-file write port between the fixed-latency multiplier pipeline exit and the normal commit/writeback path. The multiplier exit cannot stall, so it always wins; colliding writeback-path writes are held in a small in-order buffer and drained on free cycles. The block sits between the execute/commit stages and the bank register write port. It exposes a lookup port so the forward unit can bypass values that are buffered but not yet written.

## Interface
Parameters:
- REG_WIDTH, 32, data width of a register write
- NUM_REGS, 32, register count; RD_W = $clog2(NUM_REGS)
- BUF_DEPTH, 2, writeback-path buffer entries (>=1)

Ports:
- clock  in  1  clock, all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- mul_valid  in  1  multiplier final stage carries a write this cycle
- mul_rd  in  RD_W  multiplier destination register
- mul_data  in  REG_WIDTH  multiplier result
- pipe_valid  in  1  writeback path presents a write
- pipe_rd  in  RD_W  writeback-path destination
- pipe_data  in  REG_WIDTH  writeback-path value
- pipe_stall  out  1  writeback path must hold its write (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  RD_W  register-file write address (registered)
- rf_wdata  out  REG_WIDTH  register-file write data (registered)
- buf_count  out  $clog2(BUF_DEPTH+1)  current buffer occupancy
- query_rd  in  RD_W  forward-unit lookup register
- query_hit  out  1  query_rd has a pending, not-yet-written value (combinational)
- query_data  out  REG_WIDTH  youngest pending value for query_rd

## Operation
- Per-cycle port selection, in priority order:
  1. If mul_valid, the port takes the mul write.
  2. Otherwise, if the buffer is non-empty, the port takes the buffer head (pop).
  3. Otherwise, if pipe_valid, the port takes the pipe write directly (buffer bypass).
  4. Otherwise, rf_we=0 next cycle.
- A pipe write is accepted when pipe_valid && !pipe_stall.
  - Accepted and not sent to the port this cycle: it is pushed at the buffer tail.
  - Pipe writes never overtake buffered pipe writes. Direct-to-port is legal only when the buffer is empty and mul_valid=0.
- pipe_stall = mul_valid && (buf_count == BUF_DEPTH).
  - When full and mul_valid=0, a pop and a push happen in the same cycle, so there is no stall.
- The writer holds pipe_valid/pipe_rd/pipe_data stable while stalled.
- No special treatment of register 0. The block does not resolve WAW hazards between an older mul and a younger pipe write; the hazard unit prevents them.
- Same-cycle mul_valid and pipe_valid with equal rd: mul is written first, pipe is buffered and written later, so the pipe value ends in the register file.
- Lookup covers the buffer entries and the output register (a value in rf_* is not yet in the register file).
  - The youngest match wins, searching from buffer tail toward head, then the output register.
  - The search ignores this cycle's inputs.
- Reset flushes the buffer and discards any pending write. Writes lost to reset are not replayed.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, buf_count=0, buffer pointers=0.
  - pipe_stall follows its equation (0 while mul_valid=0).
  - query_hit=0 and query_data=0 after reset.
- Latency is 1 cycle from selection to rf_*:
  - mul write at cycle t appears on rf_* at t+1;
  - an unobstructed pipe write at t appears at t+1;
  - a buffered write appears one cycle after the first cycle with mul_valid=0 at which it is the head.
- Throughput is one write per cycle. The buffer drains at one entry per mul-free cycle.
- Buffer pointers wrap modulo BUF_DEPTH. Full and empty are distinguished by buf_count, not by pointer equality.
- buf_count updates on the same edge as the push/pop. It never exceeds BUF_DEPTH and never underflows.
- Reset asserted in any cycle overrides all pushes, pops and port writes at that edge.

## Test plan
- Idle to single writes: pipe write (rd=5, 0x11) at t, no mul → rf_we=1, rf_waddr=5, rf_wdata=0x11 at t+1; buf_count stays 0.
- Collision: mul (rd=3, 0xAA) and pipe (rd=7, 0xBB) at t → rf_* = (3, 0xAA) at t+1 and (7, 0xBB) at t+2; buf_count=1 during t+1.
- Backpressure, BUF_DEPTH=2: mul_valid held 4 cycles while pipe streams rd=1,2,3 → pipe_stall=1 from the third pipe write until mul drops. Then rf_* show the mul writes, followed by rd 1,2,3 in order with no loss or duplication.
- Full with mul idle: buffer full and mul_valid=0 while a pipe write arrives → pipe_stall=0, head is popped and the new write pushed; buf_count stays 2.
- Lookup: buffer holds rd=4 (0x1) then rd=4 (0x2), output register holds rd=4 (0x0) → query_rd=4 gives hit=1, data=0x2; query_rd=9 gives hit=0.
- Reset mid-operation: buffer at 2 entries and rf_we=1, reset for one cycle → next cycle rf_we=0, buf_count=0, query_hit=0; the flushed entries never appear on rf_*.
